// File: rtl/gpu_fetch_pkg.sv
// Fetch state encoding, HALT opcode and the {pc,instr} entry type.
// Also imported by control_unit so both sides decode HALT the same way.
package gpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [3:0] OPC_HALT = 4'hF;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [3:0] opcode_of(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc,instr} entries; count feeds the fetch credit check.
// Push and pop together on a full FIFO are legal and keep the count.
module fetch_fifo
    import gpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gpu_fetch_unit.sv
// Instruction fetch front end: PC, imem reads, prefetch FIFO, HALT drain.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_bubble counters.
module gpu_fetch_unit
    import gpu_fetch_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter int         DEPTH   = 4,
    parameter logic [3:0] HALT_OP = OPC_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       start_pc,
    input  logic              flush,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble,
`endif
    output logic              busy,
    output logic              halted
);

    localparam int PC_W = ADDR_W + 2;
    localparam int CW   = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic            issue;
    logic            push;
    logic            pop;
    logic            halt_hit;
    logic            start_ok;
    logic            unused_start;
    fetch_entry_t    entry;
    fetch_entry_t    head;

    assign unused_start = ^{start_pc >> PC_W, start_pc[1:0]};

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign issue      = (state == RUN) && !flush &&
                        ((int'(count) + int'(inflight)) < DEPTH);
    assign push       = inflight && (state == RUN) && !flush;
    assign halt_hit   = push && (opcode_of(imem_rdata) == HALT_OP);
    assign start_ok   = start && !flush &&
                        ((state == IDLE) || (state == HALTED));

    assign entry = '{pc: 32'(inflight_pc), instr: imem_rdata};

    assign imem_en   = issue;
    assign imem_addr = pc[PC_W-1:2];
    assign inst_data = inst_valid ? head.instr : '0;
    assign inst_pc   = inst_valid ? head.pc : '0;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign halted    = (state == HALTED);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start)      state_nx = RUN;
            RUN:     if (halt_hit)   state_nx = DRAIN;
            DRAIN:   if (!inst_valid) state_nx = HALTED;
            HALTED:  if (start)      state_nx = RUN;
            default:                 state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // The read issued alongside a returning HALT is still dropped in
    // DRAIN, but pc must not move past HALT+4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (start_ok)
                pc <= {start_pc[PC_W-1:2], 2'b00};
            else if (issue && !halt_hit)
                pc <= pc + PC_W'(4);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else if (start_ok) begin
            perf_fetched <= '0;
            perf_bubble  <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (busy && inst_ready && !inst_valid && (perf_bubble != '1))
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Directed plus randomized bench for gpu_fetch_unit.
// Expected streams come from walking the instruction memory up to HALT.
module tb_gpu_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       start_pc;
    logic              flush;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              busy;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_bubble;
`endif

    logic [31:0]       mem [256];
    int                tests = 0;
    int                fails = 0;
    int                reads;
    int                bad_reads;
    logic [ADDR_W-1:0] forbid;
    logic              forbid_on;
    logic              rand_ready;
    logic              stall_prev;
    logic [31:0]       prev_data;
    logic [31:0]       prev_pc;
    logic [31:0]       got_pc[$];
    logic [31:0]       got_data[$];
    logic [31:0]       exp_pc[$];
    logic [31:0]       exp_data[$];

    gpu_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_pc     (start_pc),
        .flush        (flush),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_data    (inst_data),
        .inst_pc      (inst_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_bubble  (perf_bubble),
`endif
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (rand_ready) inst_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (stall_prev && inst_valid) begin
            chk("stable_data", inst_data, prev_data);
            chk("stable_pc", inst_pc, prev_pc);
        end
        stall_prev = inst_valid && !inst_ready;
        prev_data  = inst_data;
        prev_pc    = inst_pc;
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        if (imem_en) begin
            reads++;
            if (forbid_on && imem_addr == forbid) bad_reads++;
        end
        @(posedge clk);
        #1;
    endtask

    // Program order: consecutive words from start_pc, wrapping, through HALT.
    task automatic build_expected(input logic [31:0] spc);
        logic [ADDR_W-1:0] a;
        a = spc[ADDR_W+1:2];
        exp_pc.delete();
        exp_data.delete();
        for (int n = 0; n < 256; n++) begin
            exp_pc.push_back(32'({a, 2'b00}));
            exp_data.push_back(mem[a]);
            if (mem[a][31:28] == 4'hF) break;
            a = a + 1'b1;
        end
        forbid    = a + 8'd2;
        forbid_on = 1'b1;
    endtask

    task automatic start_prog(input string tag, input logic [31:0] spc);
        build_expected(spc);
        got_pc.delete();
        got_data.delete();
        reads     = 0;
        bad_reads = 0;
        start_pc  = spc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_not_halted"}, halted, 0);
    endtask

    task automatic finish_prog(input string tag);
        for (int c = 0; c < 600 && !halted; c++) tick();
        chk({tag, "_halted"}, halted, 1);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_count"}, got_pc.size(), exp_pc.size());
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
            chk({tag, "_pc"}, got_pc[i], exp_pc[i]);
            chk({tag, "_data"}, got_data[i], exp_data[i]);
        end
        chk({tag, "_past_halt_read"}, bad_reads, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, imem_en, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_valid"}, inst_valid, 0);
        chk({tag, "_data"}, inst_data, 0);
        chk({tag, "_pc"}, inst_pc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] hidx;
        int                k;

        rst        = 1'b1;
        start      = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b1;
        start_pc   = '0;
        rand_ready = 1'b0;
        forbid_on  = 1'b0;
        forbid     = '0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_pc    = '0;
        reads      = 0;
        bad_reads  = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Sequential run with first-read / first-valid latency
        for (int i = 0; i < 6; i++) mem[i] = 32'h1123_0000 + 32'(i);
        mem[6] = 32'hF000_0000;
        start_prog("seq", 32'h0);
        chk("lat_en_c1", imem_en, 1);
        chk("lat_addr_c1", imem_addr, 0);
        tick();
        chk("lat_valid_c2", inst_valid, 0);
        tick();
        chk("lat_valid_c3", inst_valid, 1);
        chk("lat_pc_c3", inst_pc, 0);
        finish_prog("seq");
        chk("seq_len", got_pc.size(), 7);
        chk("seq_last_pc", got_pc[6], 32'd24);

        // Backpressure: credit limits reads to DEPTH
        inst_ready = 1'b0;
        start_prog("bp", 32'h0);
        repeat (9) tick();
        chk("bp_reads", reads, DEPTH);
        chk("bp_hold_data", inst_data, 32'h1123_0000);
        chk("bp_hold_pc", inst_pc, 0);
        inst_ready = 1'b1;
        finish_prog("bp");

        // Flush in the cycle the first read returns
        start_prog("fl", 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", inst_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_halted", halted, 0);
        chk("fl_delivered", got_pc.size(), 0);
        mem[16] = 32'h2200_0010;
        mem[17] = 32'h3300_0011;
        mem[18] = 32'hF000_0012;
        start_prog("fl40", 32'h40);
        finish_prog("fl40");
        chk("fl40_first", got_pc[0], 32'h40);

        // PC wrap at the top of the address space
        mem[255] = 32'h1234_5678;
        mem[0]   = 32'hF000_0000;
        start_prog("wrap", 32'h3FC);
        finish_prog("wrap");
        chk("wrap_len", got_pc.size(), 2);
        chk("wrap_second", got_pc[1], 32'h0);

        // Restart from HALTED
        start_prog("rs", 32'h10);
        finish_prog("rs");
        chk("rs_first", got_pc[0], 32'h10);

        // Asynchronous reset while draining
        mem[0]     = 32'h1123_0000;
        mem[1]     = 32'hF000_0001;
        inst_ready = 1'b0;
        start_prog("rd", 32'h0);
        repeat (6) tick();
        chk("rd_in_drain", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("rd_async");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        inst_ready = 1'b1;
        stall_prev = 1'b0;
        tick();
        start_prog("after_rst", 32'h0);
        finish_prog("after_rst");

        // Random programs with random decode backpressure
        rand_ready = 1'b1;
        for (int it = 0; it < 12; it++) begin
            s = ADDR_W'($urandom);
            k = $urandom_range(0, 20);
            for (int i = 0; i < 256; i++)
                mem[i] = {4'($urandom_range(0, 14)), 28'($urandom)};
            hidx = s + ADDR_W'(k);
            mem[hidx] = {4'hF, 28'($urandom)};
            start_prog("rnd", {22'd0, s, 2'($urandom)});
            finish_prog("rnd");
        end
        rand_ready = 1'b0;
        inst_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
